instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

In-order instruction fetch queue between the PC register stage and decode. It issues fetch requests for the current PC on the SRAM-like instruction bus and pulses the PC stage's advance enable on each accepted address. Returned instruction words are held with their PCs in a DEPTH-entry ring and presented to decode through a valid/ready handshake. On redirect (branch or exception) it discards the queue and silently drops any responses still in flight.

## Interface
- DEPTH, 4, ring entries; power of two, ≥2
- Clk  in  1  clock, rising edge
- Clr_n  in  1  reset, asynchronous, active-low
- flush  in  1  redirect; discard all queued and in-flight fetches
- pc  in  32  current PC from PC stage
- pc_en  out  1  advance PC stage; = inst_req & inst_addr_ok
- inst_req  out  1  fetch request valid
- inst_addr  out  32  fetch address; = pc
- inst_addr_ok  in  1  bus accepted address this cycle
- inst_data_ok  in  1  bus returns one word this cycle; responses in request order
- inst_rdata  in  32  returned instruction
- id_valid  out  1  head entry presented to decode
- id_ready  in  1  decode accepts head
- id_pc  out  32  PC of head entry
- id_instr  out  32  instruction of head entry

## Operation
- State: entry[DEPTH] = {pc, instr, done}; pointers head (pop), fill (next response), tail (next allocate), each log2(DEPTH)+1 bits with wrap bit; drop_cnt, log2(DEPTH)+1 bits.
- occupancy = tail − head (modulo, wrap bit distinguishes full from empty).
- inst_req = ~flush & (occupancy + drop_cnt < DEPTH). This guarantees a slot for every live response and bounds drop_cnt ≤ DEPTH.
- Accept (inst_req & inst_addr_ok): entry[tail] ← {pc, x, 0}; tail++.
- Response with drop_cnt ≠ 0: discarded; drop_cnt−−.
- Response with drop_cnt = 0: entry[fill].instr ← inst_rdata, done ← 1; fill++.
- id_valid = entry[head].done & (head ≠ tail) & ~flush. id_pc and id_instr come from entry[head].
- Pop (id_valid & id_ready): done ← 0; head++.
- Flush:
  - head, fill, tail ← 0; all done bits ← 0.
  - drop_cnt ← drop_cnt + (tail − fill) − inst_data_ok.
  - This formula is valid whether the coincident response is an older drop or the oldest live response, because responses arrive in order.
  - No accept or pop occurs in the flush cycle.
- Accept, response and pop in the same cycle are all independent and all take effect.
- Response arriving with no outstanding request is a bus protocol violation; behaviour is undefined (assertion in simulation).

## Timing
- Reset (async assert): pointers 0, done bits 0, drop_cnt 0. Outputs: id_valid 0; inst_req 1 once reset is deasserted and flush is low; pc_en follows inst_addr_ok.
- inst_req, inst_addr, pc_en and id_valid are combinational from registered state plus flush. All state updates on rising Clk.
- Latency: response at cycle N → id_valid at N+1 (without bypass).
- Throughput: one accept, one response and one pop per cycle.
- Full (occupancy + drop_cnt = DEPTH): inst_req low. A pop at cycle N raises inst_req at N+1.
- Reset asserted mid-operation clears all state immediately. The bus is reset on the same Clr_n.

## Configuration
- IFQ_BYPASS_EN defined:
  - When head = fill ≠ tail, drop_cnt = 0, inst_data_ok = 1 and flush = 0:
    - id_valid = 1 in the same cycle, with id_instr = inst_rdata.
    - If id_ready is high, head and fill both advance and the entry is never marked done.
    - If id_ready is low, the response is written normally.
  - Latency 0 cycles.
- IFQ_BYPASS_EN undefined: no combinational path from inst_rdata/inst_data_ok to id_*; latency 1 cycle.

## Structure
- Shared package ifq_pkg:
  - ifq_entry_t {pc[31:0], instr[31:0], done}
  - XLEN = 32
  - TEXT_ADDR = 32'hbfc00000, for benches
- One natural sub-module: ifq_ring, holding the entry storage and the head/fill/tail pointers. Top level holds drop_cnt, request gating, the bypass mux and the flush logic.

## Test plan
- Reset: Clr_n low → high, pc = 0xbfc00000 → inst_req = 1, inst_addr = 0xbfc00000, id_valid = 0.
- Single fetch: addr_ok at cycle 0; data_ok with 0x24080001 at cycle 2 → id_valid at cycle 3 (cycle 2 with IFQ_BYPASS_EN), id_pc = 0xbfc00000, id_instr = 0x24080001.
- Fill: id_ready = 0, addr_ok and data_ok every cycle, DEPTH = 4 → exactly 4 pc_en pulses, then inst_req = 0. One pop → inst_req = 1 next cycle. Order and PCs preserved.
- Flush with 2 in flight (tail − fill = 2): flush → drop_cnt = 2. Next two data_ok are discarded with id_valid = 0. A fetch of pc = 0xbfc00380 after flush is delivered with id_pc = 0xbfc00380.
- Flush coincident with data_ok and 3 outstanding → drop_cnt = 2. Flush coincident with a valid head → no pop, id_valid = 0 that cycle.
- Random addr_ok/data_ok/id_ready/flush over 10k cycles → decode stream matches a reference model of accepted PCs minus flushed ones, and drop_cnt never exceeds DEPTH.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Package : ifq_pkg
// Brief   : Shared types and constants for the instruction fetch queue.
// Rev     : 1.0
// ============================================================================
package ifq_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] TEXT_ADDR = 32'hbfc00000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            done;
  } ifq_entry_t;

  // Ring pointers carry one extra wrap bit so full and empty are distinguishable
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Interface : instr_fetch_queue_if
// Brief     : PC-stage, instruction-bus and decode signals of the fetch queue.
// Rev       : 1.0
// ============================================================================
interface instr_fetch_queue_if;
  import ifq_pkg::*;

  logic            flush;
  logic [XLEN-1:0] pc;
  logic            pc_en;
  logic            inst_req;
  logic [XLEN-1:0] inst_addr;
  logic            inst_addr_ok;
  logic            inst_data_ok;
  logic [XLEN-1:0] inst_rdata;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;

  modport master (
    input  flush, pc, inst_addr_ok, inst_data_ok, inst_rdata, id_ready,
    output pc_en, inst_req, inst_addr, id_valid, id_pc, id_instr
  );

  modport slave (
    output flush, pc, inst_addr_ok, inst_data_ok, inst_rdata, id_ready,
    input  pc_en, inst_req, inst_addr, id_valid, id_pc, id_instr
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_queue_ring.sv
`default_nettype none
// ============================================================================
// Module : ifq_ring
// Brief  : Entry storage with head (pop), fill (response) and tail (allocate).
// Rev    : 1.0
// ============================================================================
module ifq_ring import ifq_pkg::*; #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             Clk,
  input  logic             Clr_n,
  input  logic             clr_i,
  input  logic             alloc_i,
  input  logic [XLEN-1:0]  alloc_pc_i,
  input  logic             wr_i,
  input  logic [XLEN-1:0]  wr_data_i,
  input  logic             skip_i,
  input  logic             pop_i,
  output ifq_entry_t       head_ent_o,
  output logic [PTR_W-1:0] occ_o,
  output logic [PTR_W-1:0] pend_o,
  output logic             head_eq_fill_o,
  output logic             empty_o
);

  localparam int IDX_W = PTR_W - 1;

  ifq_entry_t       ent_q [DEPTH];
  ifq_entry_t       ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  logic [IDX_W-1:0] head_idx, fill_idx, tail_idx;

  assign head_idx = head_q[IDX_W-1:0];
  assign fill_idx = fill_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    fill_d = fill_q;
    tail_d = tail_q;
    if (clr_i) begin
      head_d = '0;
      fill_d = '0;
      tail_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].done = 1'b0;
      end
    end else begin
      if (alloc_i) begin
        ent_d[tail_idx].pc   = alloc_pc_i;
        ent_d[tail_idx].done = 1'b0;
        tail_d               = tail_q + PTR_W'(1);
      end
      if (wr_i) begin
        ent_d[fill_idx].instr = wr_data_i;
        ent_d[fill_idx].done  = 1'b1;
        fill_d                = fill_q + PTR_W'(1);
      end else if (skip_i) begin
        // Response consumed by decode directly; slot is retired by the pop below
        fill_d = fill_q + PTR_W'(1);
      end
      if (pop_i) begin
        ent_d[head_idx].done = 1'b0;
        head_d               = head_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      fill_q <= fill_d;
      tail_q <= tail_d;
      ent_q  <= ent_d;
    end
  end

  assign head_ent_o     = ent_q[head_idx];
  assign occ_o          = tail_q - head_q;
  assign pend_o         = tail_q - fill_q;
  assign head_eq_fill_o = (head_q == fill_q);
  assign empty_o        = (head_q == tail_q);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_queue
// Brief  : In-order fetch queue between PC stage and decode with flush drop.
//          Optional same-cycle response bypass to decode: IFQ_BYPASS_EN.
// Rev    : 1.0
// ============================================================================
module instr_fetch_queue import ifq_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Clr_n,
  instr_fetch_queue_if.master        bus
);

  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] drop_cnt_q, drop_cnt_d;

  ifq_entry_t       head_ent;
  logic [PTR_W-1:0] occ;
  logic [PTR_W-1:0] pend;
  logic             head_eq_fill;
  logic             empty;

  logic [PTR_W:0]   slots_used;
  logic             req;
  logic             accept;
  logic             live_resp;
  logic             byp_hit;
  logic             byp_take;
  logic             valid;
  logic             pop;

  // Dropped responses still need a bus slot, so they count against capacity
  assign slots_used = {1'b0, occ} + {1'b0, drop_cnt_q};
  assign req        = ~bus.flush & (slots_used < (PTR_W+1)'(DEPTH));
  assign accept     = req & bus.inst_addr_ok;
  assign live_resp  = bus.inst_data_ok & (drop_cnt_q == '0) & ~bus.flush;

`ifdef IFQ_BYPASS_EN
  assign byp_hit = live_resp & head_eq_fill & (pend != '0);
`else
  assign byp_hit = 1'b0;
`endif

  assign valid    = (head_ent.done & ~empty & ~bus.flush) | byp_hit;
  assign pop      = valid & bus.id_ready;
  assign byp_take = byp_hit & bus.id_ready;

  ifq_ring #(.DEPTH(DEPTH)) u_ring (
    .Clk            (Clk),
    .Clr_n          (Clr_n),
    .clr_i          (bus.flush),
    .alloc_i        (accept),
    .alloc_pc_i     (bus.pc),
    .wr_i           (live_resp & ~byp_take),
    .wr_data_i      (bus.inst_rdata),
    .skip_i         (byp_take),
    .pop_i          (pop),
    .head_ent_o     (head_ent),
    .occ_o          (occ),
    .pend_o         (pend),
    .head_eq_fill_o (head_eq_fill),
    .empty_o        (empty)
  );

  // A response coincident with flush is the oldest outstanding one, whether
  // it was already a drop or the first live entry, hence the subtraction.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.flush) begin
      drop_cnt_d = drop_cnt_q + pend - PTR_W'(bus.inst_data_ok);
    end else if (bus.inst_data_ok && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - PTR_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.inst_req  = req;
  assign bus.inst_addr = bus.pc;
  assign bus.pc_en     = accept;
  assign bus.id_valid  = valid;
  assign bus.id_pc     = head_ent.pc;
`ifdef IFQ_BYPASS_EN
  assign bus.id_instr  = byp_hit ? bus.inst_rdata : head_ent.instr;
`else
  assign bus.id_instr  = head_ent.instr;
`endif

`ifndef SYNTHESIS
  a_resp_outstanding: assert property (@(posedge Clk) disable iff (!Clr_n)
    bus.inst_data_ok |-> ((drop_cnt_q != '0) || (pend != '0)));
  a_drop_bound: assert property (@(posedge Clk) disable iff (!Clr_n)
    drop_cnt_q <= PTR_W'(DEPTH));
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_fetch_queue
// Brief  : Scoreboard bench for instr_fetch_queue against a queue-level model.
// Rev    : 1.0
// ============================================================================
module tb_instr_fetch_queue;
  import ifq_pkg::*;

  localparam int DEPTH = 4;

  logic Clk = 1'b0;
  logic Clr_n;

  instr_fetch_queue_if bus();

  instr_fetch_queue #(.DEPTH(DEPTH)) u_dut (
    .Clk   (Clk),
    .Clr_n (Clr_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [31:0] pc; bit live; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ex_t;

  fl_t infl[$];   // accepted, response not yet returned
  ex_t exp_q[$];  // returned, awaiting decode
  int  checks = 0;
  int  errors = 0;
  int  max_dead = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dead_cnt();
    int n = 0;
    foreach (infl[i]) if (!infl[i].live) n++;
    return n;
  endfunction

  always @(negedge Clk) begin : monitor
    bit  req_e, byp_e, vld_e, take;
    ex_t h;
    fl_t f;
    if (!Clr_n) begin
      chk("reset_id_valid", {31'b0, bus.id_valid}, 32'd0);
      chk("reset_drop_cnt", 32'(u_dut.drop_cnt_q), 32'd0);
      infl.delete();
      exp_q.delete();
    end else begin
      req_e = !bus.flush && (infl.size() + exp_q.size() < DEPTH);
      chk("inst_req", {31'b0, bus.inst_req}, {31'b0, req_e});
      chk("inst_addr", bus.inst_addr, bus.pc);
      chk("pc_en", {31'b0, bus.pc_en}, {31'b0, req_e & bus.inst_addr_ok});
      chk("drop_cnt", 32'(u_dut.drop_cnt_q), 32'(dead_cnt()));
      byp_e = 1'b0;
`ifdef IFQ_BYPASS_EN
      byp_e = !bus.flush && exp_q.size() == 0 && infl.size() > 0 &&
              infl[0].live && bus.inst_data_ok;
`endif
      vld_e = !bus.flush && (exp_q.size() > 0 || byp_e);
      chk("id_valid", {31'b0, bus.id_valid}, {31'b0, vld_e});
      take = vld_e && bus.id_ready;
      if (take) begin
        if (exp_q.size() > 0) h = exp_q.pop_front();
        else h = '{pc: infl[0].pc, instr: bus.inst_rdata};
        chk("id_pc", bus.id_pc, h.pc);
        chk("id_instr", bus.id_instr, h.instr);
      end
      if (bus.flush) begin
        if (bus.inst_data_ok && infl.size() > 0) void'(infl.pop_front());
        foreach (infl[i]) infl[i].live = 1'b0;
        exp_q.delete();
      end else begin
        if (bus.inst_data_ok && infl.size() > 0) begin
          f = infl.pop_front();
          if (f.live && !(byp_e && bus.id_ready))
            exp_q.push_back('{pc: f.pc, instr: bus.inst_rdata});
        end
        if (req_e && bus.inst_addr_ok) infl.push_back('{pc: bus.pc, live: 1'b1});
      end
      if (dead_cnt() > max_dead) max_dead = dead_cnt();
    end
  end

  // Inputs change 1 ns after the rising edge; data_ok only with a request outstanding
  task automatic cyc(input bit fl, input logic [31:0] p, input bit aok,
                     input bit dok, input logic [31:0] rd, input bit rdy);
    bus.flush        = fl;
    bus.pc           = p;
    bus.inst_addr_ok = aok;
    bus.inst_data_ok = dok && (infl.size() > 0);
    bus.inst_rdata   = rd;
    bus.id_ready     = rdy;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [31:0] p;
    Clr_n            = 1'b0;
    bus.flush        = 1'b0;
    bus.pc           = TEXT_ADDR;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
    bus.id_ready     = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Clr_n = 1'b1;

    // Single fetch: accept at cycle 0, response at cycle 2
    cyc(0, TEXT_ADDR, 1, 0, 32'h0, 1);
    cyc(0, TEXT_ADDR + 32'd4, 0, 0, 32'h0, 1);
    cyc(0, TEXT_ADDR + 32'd4, 0, 1, 32'h24080001, 1);
    cyc(0, TEXT_ADDR + 32'd4, 0, 0, 32'h0, 1);
    cyc(0, TEXT_ADDR + 32'd4, 0, 0, 32'h0, 1);

    // Fill with decode stalled, one pop, then drain
    p = TEXT_ADDR + 32'h100;
    for (int i = 0; i < 8; i++) begin
      cyc(0, p, 1, 1, $urandom, 0);
      p = p + 32'd4;
    end
    cyc(0, p, 0, 0, 32'h0, 1);
    cyc(0, p, 1, 0, 32'h0, 0);
    repeat (8) cyc(0, p, 0, 1, $urandom, 1);

    // Flush with two in flight, then fetch from the redirect target
    cyc(0, 32'hbfc00200, 1, 0, 32'h0, 0);
    cyc(0, 32'hbfc00204, 1, 0, 32'h0, 0);
    cyc(1, 32'hbfc00208, 1, 0, 32'h0, 0);
    cyc(0, 32'hbfc00380, 0, 1, 32'hdead0001, 1);
    cyc(0, 32'hbfc00380, 0, 1, 32'hdead0002, 1);
    cyc(0, 32'hbfc00380, 1, 0, 32'h0, 1);
    cyc(0, 32'hbfc00384, 0, 1, 32'h3c1d8000, 1);
    cyc(0, 32'hbfc00384, 0, 0, 32'h0, 1);

    // Flush coincident with a response and three outstanding
    for (int i = 0; i < 3; i++) cyc(0, 32'hbfc00400 + 32'(i * 4), 1, 0, 32'h0, 0);
    cyc(1, 32'hbfc00500, 0, 1, 32'h11111111, 0);
    cyc(0, 32'hbfc00500, 0, 1, 32'h22222222, 1);
    cyc(0, 32'hbfc00500, 0, 1, 32'h33333333, 1);

    // Flush coincident with a valid head: no pop that cycle
    cyc(0, 32'hbfc00600, 1, 0, 32'h0, 0);
    cyc(0, 32'hbfc00604, 0, 1, 32'h44444444, 0);
    cyc(1, 32'hbfc00604, 0, 0, 32'h0, 1);
    cyc(0, 32'hbfc00604, 0, 0, 32'h0, 1);

    // Random traffic, then reset mid-operation
    for (int i = 0; i < 40; i++)
      cyc($urandom_range(0, 99) < 3, $urandom & 32'hfffffffc,
          $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
          $urandom, $urandom_range(0, 99) < 40);
    Clr_n = 1'b0;
    cyc(0, TEXT_ADDR, 0, 0, 32'h0, 0);
    cyc(0, TEXT_ADDR, 0, 0, 32'h0, 0);
    Clr_n = 1'b1;

    for (int i = 0; i < 10000; i++)
      cyc($urandom_range(0, 99) < 3, $urandom & 32'hfffffffc,
          $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
          $urandom, $urandom_range(0, 99) < 70);

    chk("drop_bound", {31'b0, max_dead <= DEPTH}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
